// File: rtl/alu_bool_pipe_if.sv
// Request/result handshake bundle for alu_bool_pipe: valid/ready request side,
// valid/ready result side, plus the retired-error counter.
interface alu_bool_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [2:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [7:0]       err_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err, err_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err, err_cnt
  );
endinterface

// File: rtl/alu_bool_pipe.sv
// Issue/retire stage around alu_bool: request FIFO -> ALU -> result register, 1-cycle latency.
// in_ready drops only on a full FIFO; a stalled result freezes out_* and the FIFO head.
module alu_bool (
  input  logic        en_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  opcode_i,
  output logic [31:0] result_o
);
  always_comb begin
    result_o = '0;
    if (en_i && (opcode_i == 3'b000)) begin
      result_o = a_i ^ b_i;
    end
  end
endmodule

module alu_bool_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_bool_pipe_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       opcode;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             in_ready;
  logic             push;
  logic             pop;
  logic             retire;
  entry_t           head;
  entry_t           wr_entry;
  logic [31:0]      alu_result;

  // in_ready looks only at registered occupancy, never at out_ready
  assign in_ready = rst_n && (count_q != CW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign retire   = out_valid_q && bus.out_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || bus.out_ready);
  assign head     = mem_q[rd_ptr_q];
  assign wr_entry = '{a: bus.in_a, b: bus.in_b, opcode: bus.in_opcode, tag: bus.in_tag};

  alu_bool u_alu (
    .en_i     (1'b1),
    .a_i      (head.a),
    .b_i      (head.b),
    .opcode_i (head.opcode),
    .result_o (alu_result)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    err_cnt_d    = err_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (pop) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_tag_d    = head.tag;
      out_err_d    = (head.opcode != 3'b000);
    end else if (retire) begin
      out_valid_d  = 1'b0;
    end

    if (retire && out_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Entry storage needs no reset: pointers and count define what is live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_err    = out_err_q;
  assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_alu_bool_pipe.sv
// Randomized and directed bench for alu_bool_pipe against a queue-based reference model.
module tb_alu_bool_pipe;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic clk;
  logic rst_n;
  alu_bool_pipe_if #(.TAG_W(TAG_W)) bus ();

  alu_bool_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending requests plus the presented result
  req_t             q[$];
  logic             m_vld;
  logic [31:0]      m_res;
  logic [TAG_W-1:0] m_tag;
  logic             m_err;
  int               m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_in_ready();
    return rst_n && (q.size() != DEPTH);
  endfunction

  // Advance the model with the inputs currently driven, clock once, compare at negedge
  task automatic cycle();
    logic acc;
    logic push;
    logic pop;
    req_t h;
    req_t n;
    if (!rst_n) begin
      q.delete();
      m_vld = 1'b0;
      m_res = '0;
      m_tag = '0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      acc  = m_vld && bus.out_ready;
      push = bus.in_valid && (q.size() != DEPTH);
      pop  = (q.size() != 0) && (!m_vld || bus.out_ready);
      if (acc && m_err && m_cnt < 255) m_cnt++;
      if (pop) begin
        h     = q.pop_front();
        m_res = (h.op == 3'd0) ? (h.a ^ h.b) : 32'd0;
        m_tag = h.tag;
        m_err = (h.op != 3'd0);
        m_vld = 1'b1;
      end else if (acc) begin
        m_vld = 1'b0;
      end
      if (push) begin
        n.a   = bus.in_a;
        n.b   = bus.in_b;
        n.op  = bus.in_opcode;
        n.tag = bus.in_tag;
        q.push_back(n);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("in_ready", 64'(bus.in_ready), 64'(model_in_ready()));
    chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
    chk("out_result", 64'(bus.out_result), 64'(m_res));
    chk("out_tag", 64'(bus.out_tag), 64'(m_tag));
    chk("out_err", 64'(bus.out_err), 64'(m_err));
    chk("err_cnt", 64'(bus.err_cnt), 64'(m_cnt));
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    bus.in_tag    = tag;
  endtask

  task automatic rand_req(input logic force_valid, input logic [2:0] fixed_op, input logic use_fixed);
    logic [2:0] op;
    // a stalled request must stay put until accepted
    if (bus.in_valid && !model_in_ready()) return;
    op = use_fixed ? fixed_op : (($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
    set_req(force_valid ? 1'b1 : 1'($urandom_range(0, 1)), $urandom, $urandom, op, TAG_W'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    set_req(1'b0, '0, '0, '0, '0);
    cycle();
    cycle();
    chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 64'(bus.in_ready), 64'd1);

    // single XOR, result one edge after accept
    set_req(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 3'd0, 4'd3);
    cycle();
    chk("single_not_yet_valid", 64'(bus.out_valid), 64'd0);
    set_req(1'b0, '0, '0, '0, '0);
    cycle();
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_result", 64'(bus.out_result), 64'hF0F00F0F);
    chk("single_tag", 64'(bus.out_tag), 64'd3);
    bus.out_ready = 1'b1;
    cycle();

    // unsupported opcode
    set_req(1'b1, 32'h12345678, 32'h12345678, 3'b101, 4'd7);
    cycle();
    set_req(1'b0, '0, '0, '0, '0);
    cycle();
    chk("bad_op_result", 64'(bus.out_result), 64'd0);
    chk("bad_op_err", 64'(bus.out_err), 64'd1);
    cycle();
    chk("bad_op_err_cnt", 64'(bus.err_cnt), 64'd1);

    // backpressure: three pushes with out_ready low
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'hA000_0000 + 32'(i), 32'h0000_00FF, 3'd0, TAG_W'(8 + i));
      cycle();
      while (!model_in_ready() && i == 2) begin
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_head_tag_held", 64'(bus.out_tag), 64'd8);
        cycle();
        if (q.size() == DEPTH && bus.out_ready == 1'b0) bus.out_ready = 1'b1;
      end
    end
    set_req(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);
    chk("bp_last_tag", 64'(bus.out_tag), 64'd10);

    // streaming
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, $urandom, $urandom, 3'd0, TAG_W'(i));
      cycle();
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
    end
    set_req(1'b0, '0, '0, '0, '0);
    cycle();
    cycle();

    // reset mid-operation: held output + 2 queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h5555_0000 + 32'(i), 32'h1, 3'(i), TAG_W'(i + 1));
      cycle();
    end
    set_req(1'b0, '0, '0, '0, '0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_err_cnt", 64'(bus.err_cnt), 64'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("midrst_no_ghost", 64'(bus.out_valid), 64'd0);
    set_req(1'b1, 32'h0000_FFFF, 32'hFFFF_FFFF, 3'd0, 4'd9);
    cycle();
    set_req(1'b0, '0, '0, '0, '0);
    cycle();
    chk("midrst_next_result", 64'(bus.out_result), 64'hFFFF_0000);
    chk("midrst_next_tag", 64'(bus.out_tag), 64'd9);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_req(1'b0, 3'd0, 1'b0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    set_req(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // saturation
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_req(1'b1, 3'($urandom_range(1, 7)), 1'b1);
      cycle();
    end
    set_req(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    chk("sat_err_cnt", 64'(bus.err_cnt), 64'hFF);
    set_req(1'b1, 32'h1, 32'h2, 3'd6, 4'd1);
    cycle();
    set_req(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    chk("sat_hold", 64'(bus.err_cnt), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
